// File: rtl/led_fader.sv
// PWM LED output stage: accepts an on/off pattern over valid/ready and fades
// every channel toward its target with a saturating, tick-paced level ramp.
module led_fader #(
  parameter int CHANNELS  = 5,
  parameter int PWM_BITS  = 8,
  parameter int STEP_LOG2 = 12,
  parameter int FADE_STEP = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pattern,
  input  logic                pat_valid,
  output logic                pat_ready,
  output logic [CHANNELS-1:0] led
);

  localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS + 1)'(FADE_STEP);
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(FADE_STEP);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

  state_t              state_r;
  logic                ready_r;
  logic [CHANNELS-1:0] target_r;
  logic [CHANNELS-1:0] led_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [STEP_LOG2-1:0] presc_r;
  logic [PWM_BITS-1:0] level_r      [CHANNELS];
  logic [PWM_BITS-1:0] level_next_s [CHANNELS];
  logic [CHANNELS-1:0] at_goal_s;
  logic [CHANNELS-1:0] led_next_s;
  logic                tick_s;
  logic                done_s;

  assign tick_s    = &presc_r;
  assign done_s    = &at_goal_s;
  assign pat_ready = ready_r;
  assign led       = led_r;

  // Per-channel saturating fade step, goal detection and PWM compare.
  always_comb begin
    logic [PWM_BITS:0] sum_v;
    sum_v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level_next_s[i] = level_r[i];
      at_goal_s[i]    = 1'b0;
      led_next_s[i]   = 1'b0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      sum_v = {1'b0, level_r[i]} + STEP_W;
      if (target_r[i]) begin
        level_next_s[i] = (sum_v > {1'b0, MAX}) ? MAX : sum_v[PWM_BITS-1:0];
        at_goal_s[i]    = (level_r[i] == MAX);
      end else begin
        level_next_s[i] = ({1'b0, level_r[i]} >= STEP_W) ? (level_r[i] - STEP_N) : '0;
        at_goal_s[i]    = (level_r[i] == '0);
      end
      led_next_s[i] = (level_r[i] == MAX) ? 1'b1 : (level_r[i] > pwm_cnt_r);
    end
  end

  // Counters, registered LED drive and the IDLE/FADING handshake FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      target_r  <= '0;
      led_r     <= '0;
      pwm_cnt_r <= '0;
      presc_r   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level_r[i] <= '0;
      end
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
      presc_r   <= presc_r + STEP_LOG2'(1'b1);
      led_r     <= led_next_s;
      case (state_r)
        IDLE: begin
          if (pat_valid) begin
            target_r <= pattern;
            state_r  <= FADING;
            ready_r  <= 1'b0;
          end
        end
        FADING: begin
          if (tick_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
              level_r[i] <= level_next_s[i];
            end
          end
          if (done_s) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed self-checking bench for led_fader (5 channels, 16-clk ticks, step 64).
module tb_led_fader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pattern = 5'b00000;
  logic       pat_valid = 1'b0;
  logic       pat_ready;
  logic [4:0] led;

  int checks = 0;
  int fails  = 0;
  int ecnt;

  led_fader #(.CHANNELS(5), .PWM_BITS(8), .STEP_LOG2(4), .FADE_STEP(64)) dut (
    .clk(clk), .reset(reset), .pattern(pattern),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .led(led)
  );

  always #5 clk = ~clk;

  // Reference count of clocks since reset: tracks both pwm_cnt and presc phase.
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pat_valid = 1'b1; pattern = 5'b11111;
    repeat (3) step();
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_held got %b want 1", pat_ready); end
    checks++; if (led !== 5'b00000) begin fails++; $display("FAIL reset_led_held got %b want 00000", led); end
    reset = 1'b0; pat_valid = 1'b0;
    step();
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", pat_ready); end
    checks++; if (led !== 5'b00000) begin fails++; $display("FAIL reset_led got %b want 00000", led); end
    checks++; if (dut.target_r !== 5'b00000) begin fails++; $display("FAIL reset_target got %b want 00000", dut.target_r); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (dut.level_r[i] !== 8'd0) begin fails++; $display("FAIL reset_level%0d got %0d want 0", i, dut.level_r[i]); end
    end
  endtask

  task automatic test_fade_up();
    int exp_lv [4];
    logic [7:0] prev;
    int n, hi, exp_hi, bad;
    exp_lv = '{64, 128, 192, 255};
    pattern = 5'b00001; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    checks++; if (pat_ready !== 1'b0) begin fails++; $display("FAIL up_ready_drop got %b want 0", pat_ready); end
    checks++; if (dut.target_r !== 5'b00001) begin fails++; $display("FAIL up_target got %b want 00001", dut.target_r); end
    prev = 8'd0;
    for (int k = 0; k < 4; k++) begin
      n = 0; hi = 0; exp_hi = 0; bad = 0;
      do begin
        step();
        n++;
        hi += int'(led[0]);
        exp_hi += (prev == 8'd255) ? 1 : ((int'(prev) > ((ecnt - 1) % 256)) ? 1 : 0);
        if (led[4:1] !== 4'b0000) bad++;
      end while (dut.level_r[0] == prev && n < 40);
      checks++; if (dut.level_r[0] !== 8'(exp_lv[k])) begin fails++; $display("FAIL up_level_tick%0d got %0d want %0d", k, dut.level_r[0], exp_lv[k]); end
      checks++; if ((ecnt % 16) != 0) begin fails++; $display("FAIL up_tick_phase%0d got %0d want 0", k, ecnt % 16); end
      if (k > 0) begin
        checks++; if (n != 16) begin fails++; $display("FAIL up_tick_period%0d got %0d want 16", k, n); end
      end
      checks++; if (hi != exp_hi) begin fails++; $display("FAIL up_duty_level%0d got %0d want %0d", prev, hi, exp_hi); end
      checks++; if (bad != 0) begin fails++; $display("FAIL up_other_leds%0d got %0d want 0", k, bad); end
      prev = 8'(exp_lv[k]);
    end
    checks++; if (pat_ready !== 1'b0) begin fails++; $display("FAIL up_ready_at_tick4 got %b want 0", pat_ready); end
    step();
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL up_ready_return got %b want 1", pat_ready); end
    bad = 0;
    repeat (256) begin
      step();
      if (led !== 5'b00001) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL up_settled_led got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_crossfade();
    int exp0 [4];
    int exp4 [4];
    logic [7:0] prev4;
    int n;
    exp0 = '{191, 127, 63, 0};
    exp4 = '{64, 128, 192, 255};
    pattern = 5'b10000; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    checks++; if (pat_ready !== 1'b0) begin fails++; $display("FAIL xf_ready_drop got %b want 0", pat_ready); end
    prev4 = 8'd0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (dut.level_r[4] == prev4 && n < 40);
      checks++; if (dut.level_r[0] !== 8'(exp0[k])) begin fails++; $display("FAIL xf_level0_tick%0d got %0d want %0d", k, dut.level_r[0], exp0[k]); end
      checks++; if (dut.level_r[4] !== 8'(exp4[k])) begin fails++; $display("FAIL xf_level4_tick%0d got %0d want %0d", k, dut.level_r[4], exp4[k]); end
      prev4 = 8'(exp4[k]);
    end
    checks++; if (pat_ready !== 1'b0) begin fails++; $display("FAIL xf_ready_at_tick4 got %b want 0", pat_ready); end
    step();
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL xf_ready_return got %b want 1", pat_ready); end
    step();
    checks++; if (led !== 5'b10000) begin fails++; $display("FAIL xf_led got %b want 10000", led); end
  endtask

  task automatic test_hold_valid();
    int n, bad;
    pattern = 5'b00000; pat_valid = 1'b1;
    step();
    pattern = 5'b01010;
    n = 0; bad = 0;
    while (pat_ready == 1'b0 && n < 100) begin
      if (dut.target_r !== 5'b00000) bad++;
      step();
      n++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL hold_target_stable got %0d bad cycles want 0", bad); end
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL hold_ready_timeout got %b want 1", pat_ready); end
    checks++; if (dut.target_r !== 5'b00000) begin fails++; $display("FAIL hold_target_before got %b want 00000", dut.target_r); end
    step();
    pat_valid = 1'b0;
    checks++; if (dut.target_r !== 5'b01010) begin fails++; $display("FAIL hold_accept_target got %b want 01010", dut.target_r); end
    checks++; if (pat_ready !== 1'b0) begin fails++; $display("FAIL hold_accept_ready got %b want 0", pat_ready); end
    n = 0;
    while (pat_ready == 1'b0 && n < 100) begin
      step();
      n++;
    end
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL hold_settle_timeout got %b want 1", pat_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.level_r[i] !== ((i == 1 || i == 3) ? 8'd255 : 8'd0)) begin
        fails++; $display("FAIL hold_level%0d got %0d", i, dut.level_r[i]);
      end
    end
    pattern = 5'b01010; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    checks++; if (pat_ready !== 1'b0) begin fails++; $display("FAIL same_ready_low got %b want 0", pat_ready); end
    step();
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL same_ready_back got %b want 1", pat_ready); end
    checks++; if (dut.level_r[1] !== 8'd255) begin fails++; $display("FAIL same_level1 got %0d want 255", dut.level_r[1]); end
  endtask

  task automatic test_reset_mid_fade();
    int n;
    pattern = 5'b11111; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    n = 0;
    while (dut.level_r[0] != 8'd128 && n < 60) begin
      step();
      n++;
    end
    checks++; if (dut.level_r[0] !== 8'd128) begin fails++; $display("FAIL mid_level0 got %0d want 128", dut.level_r[0]); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (led !== 5'b00000) begin fails++; $display("FAIL mid_reset_led got %b want 00000", led); end
    checks++; if (pat_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b want 1", pat_ready); end
    checks++; if (dut.target_r !== 5'b00000) begin fails++; $display("FAIL mid_reset_target got %b want 00000", dut.target_r); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (dut.level_r[i] !== 8'd0) begin fails++; $display("FAIL mid_reset_level%0d got %0d want 0", i, dut.level_r[i]); end
    end
    pattern = 5'b00100; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    n = 0;
    while (dut.level_r[2] == 8'd0 && n < 40) begin
      step();
      n++;
    end
    checks++; if (n < 1 || n > 16) begin fails++; $display("FAIL post_first_tick got %0d cycles want 1..16", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.level_r[i] !== ((i == 2) ? 8'd64 : 8'd0)) begin
        fails++; $display("FAIL post_level%0d got %0d", i, dut.level_r[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_crossfade();
    test_hold_valid();
    test_reset_mid_fade();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
